// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

   localparam int unsigned PC_W = 16;

   typedef logic [PC_W-1:0] pc_t;

   localparam pc_t RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      RST_S,
      REQ_S,
      STALL_S
   } state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect target: a newer load overwrites, clear empties it.
module pc_redirect_buf
   import pc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  pc_t  i_target,
   input  logic i_clear,
   output logic o_valid,
   output pc_t  o_target
);

   logic r_valid;
   pc_t  r_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_target <= '0;
      end else if (i_clear) begin
         r_valid  <= 1'b0;
      end else if (i_load) begin
         r_valid  <= 1'b1;
         r_target <= i_target;
      end
   end

   assign o_valid  = r_valid;
   assign o_target = r_target;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch request handshake and redirect selection for the PC adder.
// Optional alignment checking on jump targets is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter pc_t RESET_PC = pc_pkg::RESET_PC,
   parameter pc_t INC      = 16'h0001
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] pcq,
   output logic [PC_W-1:0] pcb,
   input  logic [PC_W-1:0] pc_sum,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic            stall,
   input  logic            branch_valid,
   input  logic [PC_W-1:0] branch_offset,
   input  logic            jump_valid,
   input  logic [PC_W-1:0] jump_target,
   output logic            fetch_valid,
   output logic [PC_W-1:0] fetch_pc
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic            misalign_err
`endif
);

   state_t r_state;
   state_t w_state_next;
   pc_t    r_pc;
   pc_t    r_fetch_pc;
   logic   r_fetch_valid;
   logic   w_redirect;
   pc_t    w_jump_tgt;
   pc_t    w_target;
   logic   w_pend_load;
   logic   w_pend_clear;
   logic   w_pend_valid;
   pc_t    w_pend_target;

`ifdef PC_ALIGN_CHECK_EN
   logic r_misalign;

   assign w_jump_tgt = {jump_target[PC_W-1:1], 1'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (jump_valid && jump_target[0]) begin
         r_misalign <= 1'b1;
      end
   end

   assign misalign_err = r_misalign;
`else
   assign w_jump_tgt = jump_target;
`endif

   // The adder computes pc + branch_offset on a branch, pc + INC otherwise.
   assign pcq        = r_pc;
   assign pcb        = branch_valid ? branch_offset : INC;
   assign imem_addr  = r_pc;
   assign w_redirect = jump_valid | branch_valid;
   assign w_target   = jump_valid ? w_jump_tgt : pc_sum;

   // A redirect that arrives while a request is outstanding waits for the ack.
   assign w_pend_load  = (r_state == REQ_S) && !imem_ack && w_redirect;
   assign w_pend_clear = (r_state == REQ_S) && imem_ack;

   pc_redirect_buf u_redirect_buf (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_pend_load),
      .i_target (w_target),
      .i_clear  (w_pend_clear),
      .o_valid  (w_pend_valid),
      .o_target (w_pend_target)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RST_S;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         RST_S:   w_state_next = REQ_S;
         REQ_S:   if (imem_ack) w_state_next = stall ? STALL_S : REQ_S;
         STALL_S: if (!stall) w_state_next = REQ_S;
         default: w_state_next = RST_S;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      if (r_state == REQ_S) begin
         imem_req = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_fetch_valid <= 1'b0;
         r_fetch_pc    <= '0;
      end else begin
         r_fetch_valid <= 1'b0;
         if (r_state == REQ_S) begin
            if (imem_ack) begin
               if (w_redirect) begin
                  r_pc <= w_target;
               end else if (w_pend_valid) begin
                  r_pc <= w_pend_target;
               end else begin
                  r_pc          <= pc_sum;
                  r_fetch_valid <= 1'b1;
                  r_fetch_pc    <= r_pc;
               end
            end
         end else if (w_redirect) begin
            r_pc <= w_target;
         end
      end
   end

   assign fetch_valid = r_fetch_valid;
   assign fetch_pc    = r_fetch_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic vs a reference model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pcq;
   logic [15:0] pcb;
   logic [15:0] pc_sum;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic        stall;
   logic        branch_valid;
   logic [15:0] branch_offset;
   logic        jump_valid;
   logic [15:0] jump_target;
   logic        fetch_valid;
   logic [15:0] fetch_pc;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_pend_tgt;
   logic [15:0] m_fpc;
   bit          m_pend;
   bit          m_req;
   bit          m_bubble;
   bit          m_fv;
   bit          m_mis;

   always #5 clk = ~clk;

   // Stand-in for the external PC adder.
   assign pc_sum = pcq + pcb;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .pcq           (pcq),
      .pcb           (pcb),
      .pc_sum        (pc_sum),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_offset (branch_offset),
      .jump_valid    (jump_valid),
      .jump_target   (jump_target),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misalign_err  (misalign_err)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] align(input logic [15:0] t);
`ifdef PC_ALIGN_CHECK_EN
      return {t[15:1], 1'b0};
`else
      return t;
`endif
   endfunction

   task automatic model_reset();
      m_pc       = 16'h0000;
      m_pend_tgt = 16'h0000;
      m_fpc      = 16'h0000;
      m_pend     = 0;
      m_req      = 0;
      m_bubble   = 1;
      m_fv       = 0;
      m_mis      = 0;
   endtask

   // Applies one clock edge's worth of the behavioural rules to the model.
   task automatic model_step();
      bit          redir;
      bit          new_fv;
      logic [15:0] tgt;
      if (reset) begin
         model_reset();
         return;
      end
      redir  = jump_valid || branch_valid;
      tgt    = jump_valid ? align(jump_target) : 16'(m_pc + branch_offset);
      new_fv = 0;
      if (jump_valid && jump_target[0]) m_mis = 1;
      if (m_req) begin
         if (imem_ack) begin
            if (redir) begin
               m_pc = tgt;
            end else if (m_pend) begin
               m_pc = m_pend_tgt;
            end else begin
               new_fv = 1;
               m_fpc  = m_pc;
               m_pc   = 16'(m_pc + 16'd1);
            end
            m_pend = 0;
            m_req  = !stall;
         end else if (redir) begin
            m_pend     = 1;
            m_pend_tgt = tgt;
         end
      end else begin
         if (redir) m_pc = tgt;
         if (m_bubble) begin
            m_bubble = 0;
            m_req    = 1;
         end else begin
            m_req = !stall;
         end
      end
      m_fv = new_fv;
   endtask

   // Entered at a falling edge with inputs applied; returns at the next falling edge.
   task automatic cycle();
      #1;
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, m_pc);
      chk("pcq", pcq, m_pc);
      chk("pcb", pcb, branch_valid ? branch_offset : 16'h0001);
      chk("fetch_valid", fetch_valid, m_fv);
      chk("fetch_pc", fetch_pc, m_fpc);
`ifdef PC_ALIGN_CHECK_EN
      chk("misalign_err", misalign_err, m_mis);
`endif
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input bit r, input bit a, input bit s, input bit bv,
                        input logic [15:0] bo, input bit jv, input logic [15:0] jt);
      reset         = r;
      imem_ack      = a;
      stall         = s;
      branch_valid  = bv;
      branch_offset = bo;
      jump_valid    = jv;
      jump_target   = jt;
      cycle();
   endtask

   initial begin
      reset         = 1'b1;
      imem_ack      = 1'b0;
      stall         = 1'b0;
      branch_valid  = 1'b0;
      branch_offset = 16'h0000;
      jump_valid    = 1'b0;
      jump_target   = 16'h0000;
      model_reset();
      @(posedge clk);
      @(negedge clk);

      // Reset state
      drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_pc", pcq, 16'h0000);
      chk("rst_fv", fetch_valid, 1'b0);

      // One bubble, then back-to-back sequential fetches
      drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
      chk("req_after_bubble", imem_req, 1'b1);
      drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
      chk("seq_fpc0", fetch_pc, 16'h0000);
      drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
      chk("seq_fpc1", fetch_pc, 16'h0001);
      drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
      chk("seq_fpc2", fetch_pc, 16'h0002);
      chk("seq_fv2", fetch_valid, 1'b1);

      // Wrap from FFFF to 0000
      drive(0, 1, 1, 0, 16'h0, 0, 16'h0);
      drive(0, 0, 1, 1, 16'hFFFF - m_pc, 0, 16'h0);
      chk("stall_branch_pc", pcq, 16'hFFFF);
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
      chk("wrap_addr", imem_addr, 16'hFFFF);
      drive(0, 1, 1, 0, 16'h0, 0, 16'h0);
      chk("wrap_pc", pcq, 16'h0000);
      chk("wrap_fpc", fetch_pc, 16'hFFFF);
      chk("wrap_fv", fetch_valid, 1'b1);

      // Branch while waiting for a late ack
      drive(0, 0, 1, 1, 16'h0010 - m_pc, 0, 16'h0);
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
      drive(0, 0, 0, 1, 16'hFFF0, 0, 16'h0);
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
      chk("held_addr", imem_addr, 16'h0010);
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
      drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
      chk("pend_pc", pcq, 16'h0000);
      chk("pend_fv", fetch_valid, 1'b0);

      // Jump beats branch in the ack cycle
      drive(0, 1, 0, 1, 16'h0007, 1, 16'h1234);
      chk("jump_pri_pc", pcq, 16'h1234);
      chk("jump_pri_fv", fetch_valid, 1'b0);

      // Jump during a stall loads immediately
      drive(0, 1, 1, 0, 16'h0, 0, 16'h0);
      chk("stall_req", imem_req, 1'b0);
      drive(0, 0, 1, 0, 16'h0, 1, 16'h0400);
      chk("stall_jump_pc", pcq, 16'h0400);
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
      chk("unstall_req", imem_req, 1'b1);
      chk("unstall_addr", imem_addr, 16'h0400);

      // Odd jump target, then reset while a request is outstanding
      drive(0, 0, 0, 0, 16'h0, 1, 16'h0101);
      drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
      chk("odd_jump_pc", pcq, align(16'h0101));
`ifdef PC_ALIGN_CHECK_EN
      chk("misalign_set", misalign_err, 1'b1);
`endif
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
      drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
      chk("midreset_req", imem_req, 1'b0);
      chk("midreset_pc", pcq, 16'h0000);
`ifdef PC_ALIGN_CHECK_EN
      chk("misalign_clr", misalign_err, 1'b0);
`endif

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 49) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 6) == 0,
               16'($urandom),
               $urandom_range(0, 9) == 0,
               16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
